// File: rtl/regfile_writeback_arbiter.sv
// Round-robin share of the register-file writeback port; build with REGFILE_WB_STARVE_GUARD_EN for the starvation guard.
// Latency: one cycle from Req_Ready to Mem_Write_En.
// Backpressure: a requester holds Req_Valid until Req_Ready; nothing is granted while clk_en is low or in reset.
module regfile_writeback_arbiter #(
    parameter int DATABITWIDTH    = 16,
    parameter int REGADDRBITWIDTH = 4,
    parameter int REQCOUNT        = 4,
    parameter int REQIDBITWIDTH   = 2
) (
    input  logic                                  clk,
    input  logic                                  clk_en,
    input  logic                                  sync_rst,
    input  logic [REQCOUNT-1:0]                   Req_Valid,
    input  logic [REQCOUNT*REGADDRBITWIDTH-1:0]   Req_Address,
    input  logic [REQCOUNT*DATABITWIDTH-1:0]      Req_Data,
    output logic [REQCOUNT-1:0]                   Req_Ready,
    output logic                                  Mem_Write_En,
    output logic [REGADDRBITWIDTH-1:0]            Mem_Write_Address,
    output logic [DATABITWIDTH-1:0]               Mem_Write_Data,
    output logic [REQIDBITWIDTH-1:0]              Grant_Id,
`ifdef REGFILE_WB_STARVE_GUARD_EN
    output logic                                  Starve_Flag,
`endif
    output logic                                  Arbiter_Idle
);

    logic [REQIDBITWIDTH-1:0]   r_ptr;
    logic [REQIDBITWIDTH-1:0]   r_gid;
    logic                       r_wen;
    logic [REGADDRBITWIDTH-1:0] r_addr;
    logic [DATABITWIDTH-1:0]    r_data;

    logic [REQIDBITWIDTH-1:0]   w_sel;
    logic                       w_sel_vld;
    logic                       w_xfer;
    logic [REQCOUNT-1:0]        w_ready;
    logic [REGADDRBITWIDTH-1:0] w_sel_addr;
    logic [DATABITWIDTH-1:0]    w_sel_data;

`ifdef REGFILE_WB_STARVE_GUARD_EN
    logic [3:0] r_age     [REQCOUNT];
    logic [3:0] w_age_nxt [REQCOUNT];
    logic       r_starve;
    logic       w_starve_nxt;
`endif

    always_comb begin
        logic [REQIDBITWIDTH-1:0] v_idx;
        w_sel     = '0;
        w_sel_vld = 1'b0;
        v_idx     = '0;
        for (int k = 1; k <= REQCOUNT; k++) begin
            v_idx = REQIDBITWIDTH'((int'(r_ptr) + k) % REQCOUNT);
            if (!w_sel_vld && Req_Valid[v_idx]) begin
                w_sel_vld = 1'b1;
                w_sel     = v_idx;
            end
        end
`ifdef REGFILE_WB_STARVE_GUARD_EN
        // Aged requesters override round-robin; descending scan leaves the lowest index.
        for (int i = REQCOUNT - 1; i >= 0; i--) begin
            if (Req_Valid[i] && (r_age[i] >= 4'd12)) begin
                w_sel_vld = 1'b1;
                w_sel     = REQIDBITWIDTH'(i);
            end
        end
`endif
    end

    assign w_xfer     = clk_en && !sync_rst && w_sel_vld;
    assign w_ready    = w_xfer ? (REQCOUNT'(1) << w_sel) : '0;
    assign w_sel_addr = Req_Address[int'(w_sel)*REGADDRBITWIDTH +: REGADDRBITWIDTH];
    assign w_sel_data = Req_Data[int'(w_sel)*DATABITWIDTH +: DATABITWIDTH];

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            r_ptr  <= REQIDBITWIDTH'(REQCOUNT - 1);
            r_gid  <= '0;
            r_wen  <= 1'b0;
            r_addr <= '0;
            r_data <= '0;
        end else if (clk_en) begin
            if (w_xfer) begin
                r_ptr  <= w_sel;
                r_gid  <= w_sel;
                r_addr <= w_sel_addr;
                r_data <= w_sel_data;
                // Register 0 is hardwired; accept the return but never strobe it.
                r_wen  <= |w_sel_addr;
            end else begin
                r_wen  <= 1'b0;
            end
        end
    end

`ifdef REGFILE_WB_STARVE_GUARD_EN
    always_comb begin
        w_starve_nxt = 1'b0;
        for (int i = 0; i < REQCOUNT; i++) begin
            w_age_nxt[i] = r_age[i];
            if (w_ready[i]) begin
                w_age_nxt[i] = 4'd0;
            end else if (Req_Valid[i] && (r_age[i] != 4'hF)) begin
                w_age_nxt[i] = r_age[i] + 4'd1;
            end
            if (w_age_nxt[i] >= 4'd12) begin
                w_starve_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            for (int i = 0; i < REQCOUNT; i++) begin
                r_age[i] <= 4'd0;
            end
            r_starve <= 1'b0;
        end else if (clk_en) begin
            for (int i = 0; i < REQCOUNT; i++) begin
                r_age[i] <= w_age_nxt[i];
            end
            r_starve <= w_starve_nxt;
        end
    end

    assign Starve_Flag = r_starve;
`endif

    assign Req_Ready         = w_ready;
    assign Mem_Write_En      = r_wen;
    assign Mem_Write_Address = r_addr;
    assign Mem_Write_Data    = r_data;
    assign Grant_Id          = r_gid;
    assign Arbiter_Idle      = ~|Req_Valid && ~r_wen;

endmodule
